stream_elements: RTL
====================

STREAM_ELEMENTS -- requirements
Module: stream_elements

Interface
REQ-001 SHALL have parameter RESOLUTION, default 8: bit width of one signed element.
REQ-002 SHALL have parameter INPUT_DATA_SIZE, default 16: elements per flattened vector.
REQ-003 SHALL have parameter LANES, default 4: elements emitted per beat, 1..INPUT_DATA_SIZE.
REQ-004 SHALL have derived parameter BEATS = ceil(INPUT_DATA_SIZE/LANES) and INDEX_WIDTH = max(1, clog2(INPUT_DATA_SIZE)).
REQ-005 SHALL have port clk, input, 1: single clock; all state rises on posedge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1: request to begin streaming one vector pair.
REQ-008 SHALL have port abort, input, 1: terminate current stream.
REQ-009 SHALL have port input_data, input, RESOLUTION*INPUT_DATA_SIZE: flattened input vector, element i at bits [(i+1)*RESOLUTION-1 -: RESOLUTION].
REQ-010 SHALL have port weight, input, RESOLUTION*INPUT_DATA_SIZE: flattened weight vector, same packing.
REQ-011 SHALL have port out_valid, output, 1: beat present.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts beat.
REQ-013 SHALL have port input_lanes, output, RESOLUTION*LANES: signed elements, lane k in slice k.
REQ-014 SHALL have port weight_lanes, output, RESOLUTION*LANES: signed weights, lane k in slice k.
REQ-015 SHALL have port lane_mask, output, LANES: bit k set when lane k holds a real element.
REQ-016 SHALL have port base_index, output, INDEX_WIDTH: element index carried by lane 0.
REQ-017 SHALL have port last, output, 1: current beat is final beat of vector.
REQ-018 SHALL have ports busy and done, output, 1 each: streaming active; one-cycle completion pulse.

Function
REQ-019 SHALL implement FSM IDLE -> LOAD -> STREAM -> IDLE.
REQ-020 In IDLE, start=1 SHALL capture input_data and weight into internal snapshot registers and go to LOAD; later input changes SHALL not affect the stream.
REQ-021 LOAD SHALL last exactly one cycle; first beat SHALL have out_valid=1 in the cycle after LOAD (start-to-first-valid latency 2 cycles).
REQ-022 Beat b SHALL carry elements b*LANES+k for k=0..LANES-1; base_index = b*LANES.
REQ-023 Lanes with index >= INPUT_DATA_SIZE SHALL output zero in both input_lanes and weight_lanes and have lane_mask bit cleared.
REQ-024 out_valid and all beat outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 Beat transfer occurs when out_valid=1 and out_ready=1; next beat SHALL be presented the following cycle, giving one beat per cycle with out_ready held high.
REQ-026 last SHALL be 1 only on beat BEATS-1; its transfer SHALL return FSM to IDLE and pulse done for one cycle.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort in LOAD or STREAM SHALL return to IDLE next cycle, drop out_valid, and not pulse done; abort has priority over a simultaneous transfer.
REQ-029 start and abort asserted together in IDLE: abort wins, no stream begins.
REQ-030 busy SHALL be 1 in LOAD and STREAM.
REQ-031 When out_valid=0, input_lanes, weight_lanes, lane_mask SHALL be zero.
REQ-032 LANES = INPUT_DATA_SIZE SHALL yield one beat with last=1.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE, out_valid=0, done=0, busy=0, last=0, base_index=0, lane_mask=0, lanes and snapshots zero.
REQ-034 Reset mid-stream SHALL discard the stream; first cycle after release SHALL be IDLE.

Structure
REQ-035 RESOLUTION default, FSM state encodings and the BEATS/INDEX_WIDTH derivation SHALL live in the shared neural-network parameter package.
REQ-036 Per-lane slice/zero-fill logic SHALL be sub-module lane_select (one instance per lane, combinational, snapshot+index -> element, valid).

Verification
REQ-037 SIZE=16, LANES=4, input element i=i+1, weight i=-i, out_ready=1, start pulse -> 4 beats on consecutive cycles, beat 0 input_lanes {4,3,2,1}, last on beat 3, done one cycle after.
REQ-038 SIZE=10, LANES=4 -> 3 beats; beat 2 lane_mask=4'b0011, lanes 2-3 zero, base_index=8.
REQ-039 out_ready toggled 1,0,0,1 during beat 1 -> beat 1 held 3 cycles unchanged, no element skipped or duplicated.
REQ-040 Change input_data one cycle after start -> streamed values equal snapshot at start.
REQ-041 abort during beat 2 -> out_valid 0 next cycle, no done; rst_n low mid-stream -> all outputs zero immediately.
REQ-042 start during STREAM and start+abort in IDLE -> ignored, busy unchanged.

Source files
------------

// File: rtl/stream_elements_pkg.sv
// Shared neural-network parameter package for the element streamer.
// Holds the default element resolution, the streamer FSM state encoding and
// helpers that derive the beat count and index width from the vector geometry.
package stream_elements_pkg;

  localparam int unsigned RESOLUTION_DEFAULT = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StStream = 2'd2
  } stream_state_e;

  // ceil(size / lanes)
  function automatic int unsigned calc_beats(int unsigned size, int unsigned lanes);
    return (size + lanes - 1) / lanes;
  endfunction

  // max(1, clog2(n)); a single-entry range still needs one index bit
  function automatic int unsigned calc_index_width(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lane_select.sv
// Per-lane element picker (combinational).
// Selects element index_i out of the input and weight snapshots. Indices past
// the end of the vector produce zero elements and a cleared valid flag.
// Ports:
//   input_snap_i  / weight_snap_i : flattened snapshot vectors
//   index_i                       : element index served by this lane
//   input_elem_o  / weight_elem_o : selected elements (zero when out of range)
//   valid_o                       : index_i addresses a real element
module lane_select
  import stream_elements_pkg::*;
#(
  parameter int unsigned RESOLUTION      = RESOLUTION_DEFAULT,
  parameter int unsigned INPUT_DATA_SIZE = 16,
  parameter int unsigned IDX_W           = 5
) (
  input  logic [RESOLUTION*INPUT_DATA_SIZE-1:0] input_snap_i,
  input  logic [RESOLUTION*INPUT_DATA_SIZE-1:0] weight_snap_i,
  input  logic [IDX_W-1:0]                      index_i,
  output logic [RESOLUTION-1:0]                 input_elem_o,
  output logic [RESOLUTION-1:0]                 weight_elem_o,
  output logic                                  valid_o
);

  // Explicit compare-per-element mux keeps the out-of-range case free of
  // out-of-bounds part-selects.
  always_comb begin
    input_elem_o  = '0;
    weight_elem_o = '0;
    valid_o       = 1'b0;
    for (int unsigned i = 0; i < INPUT_DATA_SIZE; i++) begin
      if (index_i == IDX_W'(i)) begin
        input_elem_o  = input_snap_i[i*RESOLUTION +: RESOLUTION];
        weight_elem_o = weight_snap_i[i*RESOLUTION +: RESOLUTION];
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_elements.sv
// Element streamer: snapshots an input/weight vector pair on start and emits
// it LANES elements per beat over a valid/ready interface.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, abort          : begin a stream (when idle) / drop the current one
//   input_data, weight    : flattened vectors, element i at [(i+1)*RES-1 -: RES]
//   out_valid, out_ready  : beat handshake
//   input_lanes,
//   weight_lanes          : lane k in slice k, zero when not valid or past end
//   lane_mask             : lane k holds a real element
//   base_index            : element index carried by lane 0
//   last                  : final beat of the vector
//   busy, done            : stream active / one-cycle completion pulse
module stream_elements
  import stream_elements_pkg::*;
#(
  parameter int unsigned RESOLUTION      = RESOLUTION_DEFAULT,
  parameter int unsigned INPUT_DATA_SIZE = 16,
  parameter int unsigned LANES           = 4,
  localparam int unsigned BEATS          = calc_beats(INPUT_DATA_SIZE, LANES),
  localparam int unsigned INDEX_WIDTH    = calc_index_width(INPUT_DATA_SIZE)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [RESOLUTION*INPUT_DATA_SIZE-1:0] input_data,
  input  logic [RESOLUTION*INPUT_DATA_SIZE-1:0] weight,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [RESOLUTION*LANES-1:0]           input_lanes,
  output logic [RESOLUTION*LANES-1:0]           weight_lanes,
  output logic [LANES-1:0]                      lane_mask,
  output logic [INDEX_WIDTH-1:0]                base_index,
  output logic                                  last,
  output logic                                  busy,
  output logic                                  done
);

  localparam int unsigned BeatW = calc_index_width(BEATS);
  // One extra bit so lanes of the final partial beat can point past the end.
  localparam int unsigned IdxW  = INDEX_WIDTH + 1;

  stream_state_e                         state_q, state_d;
  logic [BeatW-1:0]                      beat_q, beat_d;
  logic [RESOLUTION*INPUT_DATA_SIZE-1:0] input_snap_q, input_snap_d;
  logic [RESOLUTION*INPUT_DATA_SIZE-1:0] weight_snap_q, weight_snap_d;
  logic                                  done_q, done_d;

  logic            is_last;
  logic [IdxW-1:0] base_wide;

  assign is_last   = (beat_q == BeatW'(BEATS - 1));
  assign base_wide = IdxW'(beat_q) * IdxW'(LANES);

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    input_snap_d  = input_snap_q;
    weight_snap_d = weight_snap_q;
    done_d        = 1'b0;
    unique case (state_q)
      StIdle: begin
        // abort outranks a simultaneous start
        if (start && !abort) begin
          state_d       = StLoad;
          input_snap_d  = input_data;
          weight_snap_d = weight;
        end
      end
      StLoad: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          state_d = StStream;
          beat_d  = '0;
        end
      end
      StStream: begin
        // abort outranks a simultaneous transfer and suppresses done
        if (abort) begin
          state_d = StIdle;
        end else if (out_ready) begin
          if (is_last) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      beat_q        <= '0;
      input_snap_q  <= '0;
      weight_snap_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      input_snap_q  <= input_snap_d;
      weight_snap_q <= weight_snap_d;
      done_q        <= done_d;
    end
  end

  // Beat outputs decode straight from registered state, so they cannot move
  // while a beat is stalled and clear as soon as reset asserts.
  assign out_valid  = (state_q == StStream);
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign last       = out_valid && is_last;
  assign base_index = out_valid ? base_wide[INDEX_WIDTH-1:0] : '0;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [IdxW-1:0]       lane_index;
    logic [RESOLUTION-1:0] in_elem;
    logic [RESOLUTION-1:0] wt_elem;
    logic                  elem_valid;

    assign lane_index = base_wide + IdxW'(k);

    lane_select #(
      .RESOLUTION      (RESOLUTION),
      .INPUT_DATA_SIZE (INPUT_DATA_SIZE),
      .IDX_W           (IdxW)
    ) u_lane_select (
      .input_snap_i  (input_snap_q),
      .weight_snap_i (weight_snap_q),
      .index_i       (lane_index),
      .input_elem_o  (in_elem),
      .weight_elem_o (wt_elem),
      .valid_o       (elem_valid)
    );

    assign input_lanes[k*RESOLUTION +: RESOLUTION]  = out_valid ? in_elem : '0;
    assign weight_lanes[k*RESOLUTION +: RESOLUTION] = out_valid ? wt_elem : '0;
    assign lane_mask[k]                             = out_valid && elem_valid;
  end

endmodule
